mdu_alu: RTL and testbench

- Parametrised, registered successor to the combinational datapath ALU of the multicycle MIPS core.
- Executes single-cycle integer ops (add/sub/or/slt/sltu/lui-pass/bltz test) with signed-overflow detection.
- Adds an iterative multiply/divide unit with HI/LO registers and a start/busy/done handshake, so the control FSM can stall on long ops.

---
 rtl/mdu_alu_pkg.sv | 37 +++
 rtl/mdu_alu_mdu_iter.sv | 135 +++++++++++++
 rtl/mdu_alu.sv | 126 ++++++++++++
 tb/tb_mdu_alu.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_alu_pkg.sv
// Shared op codes, FSM state encoding and small decode helpers for mdu_alu.
// The iterative multiply/divide unit is built only when MDU_ALU_MDU_EN is defined.
package mdu_alu_pkg;

  typedef enum logic [3:0] {
    ADD   = 4'd0,
    SUB   = 4'd1,
    OR    = 4'd2,
    SLT   = 4'd3,
    SLTU  = 4'd4,
    ADDO  = 4'd5,
    SUBO  = 4'd6,
    PASSB = 4'd7,
    BLTZ  = 4'd8,
    MFHI  = 4'd9,
    MFLO  = 4'd10,
    MULT  = 4'd11,
    MULTU = 4'd12,
    DIV   = 4'd13,
    DIVU  = 4'd14
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic is_mdu_op(input op_t op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic is_signed_mdu_op(input op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/mdu_alu_mdu_iter.sv
// Iterative multiply/divide engine: shift-add multiply or restoring divide on
// operand magnitudes, one bit per cycle, with a final sign-fix cycle.
module mdu_iter
  import mdu_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output state_t           state
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Unsigned ops see clear sign bits, so their magnitudes are the raw operands.
  always_comb begin
    sign_a = is_signed_mdu_op(op) & a[WIDTH-1];
    sign_b = is_signed_mdu_op(op) & b[WIDTH-1];
    mag_a  = sign_a ? (~a + 1'b1) : a;
    mag_b  = sign_b ? (~b + 1'b1) : b;
  end

  // acc_hi holds the partial product (multiply) or partial remainder (divide);
  // acc_lo holds the multiplier being shifted out or the quotient being shifted in.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_trial = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opnd};
    prod_fix  = neg_q ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};
    quo_fix   = div_zero ? '1 : (neg_q ? (~acc_lo + 1'b1) : acc_lo);
    rem_fix   = neg_r ? (~acc_hi + 1'b1) : acc_hi;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= mag_a;
            opnd     <= mag_b;
            is_div   <= (op == DIV) || (op == DIVU);
            neg_q    <= sign_a ^ sign_b;
            neg_r    <= sign_a;
            div_zero <= (b == '0);
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            if (!div_diff[WIDTH]) begin
              acc_hi <= div_diff[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= div_trial[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mdu_alu.sv
// Registered MIPS-style ALU with optional iterative MDU (macro MDU_ALU_MDU_EN).
// WIDTH must be even and at least 8.
module mdu_alu
  import mdu_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             alu_src,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] imm_in,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             bltz_flag,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  // Handshake: an op is accepted on a rising edge where start=1 and busy=0;
  // starts seen while busy=1 are dropped. done pulses for exactly one cycle per
  // accepted op, and a new start may be accepted in that same cycle.

  op_t              op_e;
  logic [WIDTH-1:0] opb;
  logic             accept;
  logic             mdu_go;
  logic             mdu_done;
  logic             done_sc;
  logic [WIDTH:0]   sum_x;
  logic [WIDTH:0]   dif_x;
  logic [WIDTH-1:0] res_nx;
  logic             ovf_nx;
  logic             bltz_nx;

  assign op_e   = op_t'(op);
  assign opb    = alu_src ? imm_in : b_in;
  assign accept = start & ~busy;

`ifdef MDU_ALU_MDU_EN
  state_t mdu_state;

  assign mdu_go = accept & is_mdu_op(op_e);
  assign busy   = (mdu_state != IDLE);

  mdu_iter #(
    .WIDTH (WIDTH)
  ) u_mdu_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mdu_go),
    .op    (op_e),
    .a     (a_in),
    .b     (b_in),
    .done  (mdu_done),
    .hi    (hi_out),
    .lo    (lo_out),
    .state (mdu_state)
  );
`else
  assign mdu_go   = 1'b0;
  assign mdu_done = 1'b0;
  assign busy     = 1'b0;
  assign hi_out   = '0;
  assign lo_out   = '0;
`endif

  // Sign-extending by one bit makes signed overflow visible as bit[W] != bit[W-1].
  always_comb begin
    sum_x   = {a_in[WIDTH-1], a_in} + {opb[WIDTH-1], opb};
    dif_x   = {a_in[WIDTH-1], a_in} - {opb[WIDTH-1], opb};
    res_nx  = '0;
    ovf_nx  = 1'b0;
    bltz_nx = 1'b0;
    case (op_e)
      ADD:   res_nx = sum_x[WIDTH-1:0];
      SUB:   res_nx = dif_x[WIDTH-1:0];
      OR:    res_nx = a_in | opb;
      SLT:   res_nx = {{(WIDTH-1){1'b0}}, ($signed(a_in) < $signed(opb))};
      SLTU:  res_nx = {{(WIDTH-1){1'b0}}, (a_in < opb)};
      ADDO: begin
        res_nx = sum_x[WIDTH-1:0];
        ovf_nx = sum_x[WIDTH] ^ sum_x[WIDTH-1];
      end
      SUBO: begin
        res_nx = dif_x[WIDTH-1:0];
        ovf_nx = dif_x[WIDTH] ^ dif_x[WIDTH-1];
      end
      PASSB: res_nx = opb;
      BLTZ: begin
        res_nx  = {{(WIDTH-1){1'b0}}, a_in[WIDTH-1]};
        bltz_nx = a_in[WIDTH-1];
      end
      MFHI:  res_nx = hi_out;
      MFLO:  res_nx = lo_out;
      default: ;
    endcase
  end

  // MDU ops leave result untouched but still clear the flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= '0;
      overflow  <= 1'b0;
      bltz_flag <= 1'b0;
      done_sc   <= 1'b0;
    end else begin
      done_sc <= accept & ~mdu_go;
      if (accept) begin
        overflow  <= ovf_nx;
        bltz_flag <= bltz_nx;
        if (!mdu_go) result <= res_nx;
      end
    end
  end

  assign zero = (result == '0);
  assign done = done_sc | mdu_done;

endmodule

// File: tb/tb_mdu_alu.sv
// Self-checking bench for mdu_alu: directed vector table, hand-written MDU
// sequences and randomized ops checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_mdu_alu;
  import mdu_alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = 4'd0;
  logic         alu_src = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic [W-1:0] imm_in = '0;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic         bltz_flag;
  logic         busy;
  logic         done;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] imm;
    logic         src;
    logic [W-1:0] res;
    logic         ovf;
    logic         bz;
  } vec_t;

  vec_t vecs[16];

  mdu_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .alu_src   (alu_src),
    .a_in      (a_in),
    .b_in      (b_in),
    .imm_in    (imm_in),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .bltz_flag (bltz_flag),
    .busy      (busy),
    .done      (done),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_sc(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output logic ov, output logic bz);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    ov = 1'b0;
    bz = 1'b0;
    case (o)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a | b;
      4'd3: r = (sa < sb) ? 1 : 0;
      4'd4: r = (a < b) ? 1 : 0;
      4'd5: begin s = sa + sb; r = W'(s); ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd6: begin s = sa - sb; r = W'(s); ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd7: r = b;
      4'd8: begin bz = (sa < 0); r = bz ? 1 : 0; end
      4'd9: r = model_hi;
      4'd10: r = model_lo;
      default: r = '0;
    endcase
  endtask

  task automatic model_mdu(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] h, output logic [W-1:0] l);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h  = '0;
    l  = '0;
    if (o == MULT) begin
      p = 64'(sa * sb);
      h = p[63:32];
      l = p[31:0];
    end else if (o == MULTU) begin
      p = {32'b0, a} * {32'b0, b};
      h = p[63:32];
      l = p[31:0];
    end else if (b == '0) begin
      l = '1;
      h = a;
    end else if (o == DIV) begin
      q = sa / sb;
      r = sa % sb;
      l = W'(q);
      h = W'(r);
    end else begin
      q = longint'({32'b0, a}) / longint'({32'b0, b});
      r = longint'({32'b0, a}) % longint'({32'b0, b});
      l = W'(q);
      h = W'(r);
    end
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'hFFFF_FFFF;
      3: return W'($urandom_range(0, 20));
      default: return W'($urandom());
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] imm, input logic src);
    op = o; a_in = a; b_in = b; imm_in = imm; alu_src = src; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges after the start edge until done is seen, bounded at 100.
  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (!done && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic run_mdu(input string name, input logic [3:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    int k;
    logic [W-1:0] res_before;
    res_before = result;
    issue(o, a, b, '0, 1'b0);
    check1({name, " busy"}, busy, 1'b1);
    check1({name, " no early done"}, done, 1'b0);
    wait_done(0, k);
    check_int({name, " latency"}, k, W + 1);
    check1({name, " busy end"}, busy, 1'b0);
    check({name, " hi"}, hi_out, eh);
    check({name, " lo"}, lo_out, el);
    check({name, " result kept"}, result, res_before);
    model_hi = eh;
    model_lo = el;
  endtask

  // ---------------- test ----------------
  initial begin
    logic [W-1:0] er, eh, el, a, b, imm;
    logic         eo, ebz, src;
    logic [3:0]   o;
    int           k, pulses;

    vecs[0]  = '{ADDO,  32'h7FFF_FFFF, 32'h0000_0001, 32'h0,         1'b0, 32'h8000_0000, 1'b1, 1'b0};
    vecs[1]  = '{ADD,   32'h7FFF_FFFF, 32'h0000_0001, 32'h0,         1'b0, 32'h8000_0000, 1'b0, 1'b0};
    vecs[2]  = '{SLT,   32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0,         1'b0, 32'h1,         1'b0, 1'b0};
    vecs[3]  = '{SLTU,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0,         1'b0, 32'h1,         1'b0, 1'b0};
    vecs[4]  = '{SLT,   32'h0000_0005, 32'hFFFF_FFFF, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0};
    vecs[5]  = '{BLTZ,  32'h8000_0000, 32'h0,         32'h0,         1'b0, 32'h1,         1'b0, 1'b1};
    vecs[6]  = '{BLTZ,  32'h7FFF_FFFF, 32'h0,         32'h0,         1'b0, 32'h0,         1'b0, 1'b0};
    vecs[7]  = '{SUBO,  32'h8000_0000, 32'h0000_0001, 32'h0,         1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0};
    vecs[8]  = '{OR,    32'h0000_00F0, 32'hFFFF_0000, 32'h0000_000F, 1'b1, 32'h0000_00FF, 1'b0, 1'b0};
    vecs[9]  = '{PASSB, 32'h1111_1111, 32'h2222_2222, 32'h0000_1234, 1'b1, 32'h0000_1234, 1'b0, 1'b0};
    vecs[10] = '{SUB,   32'h0000_0005, 32'h0000_0005, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0};
    vecs[11] = '{4'd15, 32'h0000_0001, 32'h0000_0002, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0};
    vecs[12] = '{ADDO,  32'h8000_0000, 32'h0,         32'hFFFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0};
    vecs[13] = '{SLT,   32'h8000_0000, 32'h7FFF_FFFF, 32'h0,         1'b0, 32'h1,         1'b0, 1'b0};
    vecs[14] = '{SLT,   32'h7FFF_FFFF, 32'h8000_0000, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0};
    vecs[15] = '{SUBO,  32'h0000_0005, 32'h0000_0003, 32'h0,         1'b0, 32'h0000_0002, 1'b0, 1'b0};

    // reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset result", result, '0);
    check1("reset zero", zero, 1'b1);
    check1("reset overflow", overflow, 1'b0);
    check1("reset bltz", bltz_flag, 1'b0);
    check1("reset busy", busy, 1'b0);
    check1("reset done", done, 1'b0);
    check("reset hi", hi_out, '0);
    check("reset lo", lo_out, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed single-cycle table
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].src);
      check($sformatf("vec%0d result", i), result, vecs[i].res);
      check1($sformatf("vec%0d zero", i), zero, (vecs[i].res == '0));
      check1($sformatf("vec%0d overflow", i), overflow, vecs[i].ovf);
      check1($sformatf("vec%0d bltz", i), bltz_flag, vecs[i].bz);
      check1($sformatf("vec%0d done", i), done, 1'b1);
      check1($sformatf("vec%0d busy", i), busy, 1'b0);
      @(posedge clk); #1;
      check1($sformatf("vec%0d done drop", i), done, 1'b0);
      check($sformatf("vec%0d result hold", i), result, vecs[i].res);
    end

    // randomized single-cycle ops against the model
    for (int i = 0; i < 80; i++) begin
      k   = $urandom_range(0, 11);
      o   = (k == 11) ? 4'd15 : 4'(k);
      a   = pick_val();
      b   = pick_val();
      imm = pick_val();
      src = 1'($urandom_range(0, 1));
      model_sc(o, a, src ? imm : b, er, eo, ebz);
      exp_q.push_back(er);
      issue(o, a, b, imm, src);
      check($sformatf("rnd%0d op%0d result", i, o), result, exp_q.pop_front());
      check1($sformatf("rnd%0d overflow", i), overflow, eo);
      check1($sformatf("rnd%0d bltz", i), bltz_flag, ebz);
      check1($sformatf("rnd%0d done", i), done, 1'b1);
    end

`ifdef MDU_ALU_MDU_EN
    // back-to-back runs also exercise a start accepted in the done cycle
    run_mdu("mult -3*7", MULT, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_mdu("div -7/2", DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_mdu("divu 7/0", DIVU, 32'h7, 32'h0, 32'h7, 32'hFFFF_FFFF);
    run_mdu("div min/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_mdu("div -9/0", DIV, 32'hFFFF_FFF7, 32'h0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
    run_mdu("multu max*max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_mdu("mult -3*7 again", MULT, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    issue(MFLO, '0, '0, '0, 1'b0);
    check("mflo", result, 32'hFFFF_FFEB);
    issue(MFHI, '0, '0, '0, 1'b0);
    check("mfhi", result, 32'hFFFF_FFFF);

    // a start pulse mid-operation must be ignored
    issue(DIVU, 32'd100, 32'd7, '0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    op = MULT; a_in = 32'd3; b_in = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(6, k);
    check_int("divu ignore-start latency", k, W + 1);
    check("divu 100/7 lo", lo_out, 32'd14);
    check("divu 100/7 hi", hi_out, 32'd2);
    @(posedge clk); #1;
    check1("no queued op busy", busy, 1'b0);
    check1("no queued op done", done, 1'b0);

    // reset in the middle of a multiply
    issue(ADD, 32'd1, 32'd2, '0, 1'b0);
    issue(MULT, 32'h1234_5678, 32'h9, '0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset result", result, '0);
    check1("midreset zero", zero, 1'b1);
    check1("midreset busy", busy, 1'b0);
    check1("midreset done", done, 1'b0);
    check("midreset hi", hi_out, '0);
    check("midreset lo", lo_out, '0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check_int("midreset no done", pulses, 0);
    model_hi = '0;
    model_lo = '0;

    // randomized MDU ops against the model
    for (int i = 0; i < 12; i++) begin
      k = $urandom_range(0, 3);
      o = (k == 0) ? MULT : (k == 1) ? MULTU : (k == 2) ? DIV : DIVU;
      a = pick_val();
      b = ($urandom_range(0, 7) == 0) ? '0 : pick_val();
      model_mdu(o, a, b, eh, el);
      exp_q.push_back(eh);
      exp_q.push_back(el);
      eh = exp_q.pop_front();
      el = exp_q.pop_front();
      run_mdu($sformatf("rmdu%0d op%0d %h,%h", i, o, a, b), o, a, b, eh, el);
      issue(MFHI, '0, '0, '0, 1'b0);
      check($sformatf("rmdu%0d mfhi", i), result, model_hi);
    end
`else
    issue(ADD, 32'd1, 32'd2, '0, 1'b0);
    issue(MULT, 32'hFFFF_FFFD, 32'h7, '0, 1'b0);
    check1("nomdu mult done", done, 1'b1);
    check1("nomdu mult busy", busy, 1'b0);
    check("nomdu mult result", result, '0);
    check("nomdu hi", hi_out, '0);
    check("nomdu lo", lo_out, '0);
    @(posedge clk); #1;
    check1("nomdu busy after", busy, 1'b0);
    check1("nomdu done drop", done, 1'b0);
    issue(ADD, 32'd1, 32'd2, '0, 1'b0);
    issue(DIVU, 32'h7, 32'h0, '0, 1'b0);
    check("nomdu divu result", result, '0);
    check1("nomdu divu done", done, 1'b1);
    issue(ADD, 32'd4, 32'd5, '0, 1'b0);
    issue(MFHI, '0, '0, '0, 1'b0);
    check("nomdu mfhi", result, '0);
    check1("nomdu mfhi zero", zero, 1'b1);
    issue(ADD, 32'd4, 32'd5, '0, 1'b0);
    issue(MFLO, '0, '0, '0, 1'b0);
    check("nomdu mflo", result, '0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
